// File: rtl/ahb_cmd_arbiter_pkg.sv
// Shared types and AHB encodings for the command arbiter.
package ahb_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE,
        ST_DONE
    } arb_state_t;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

endpackage

// File: rtl/ahb_cmd_arbiter_if.sv
// Command port between the arbiter and the downstream AHB master engine.
interface ahb_cmd_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  start_trans;
    logic                  stop_trans;
    logic [ADDR_WIDTH-1:0] ext_haddr;
    logic [DATA_WIDTH-1:0] ext_hwdata;
    logic                  ext_hwrite;
    logic [2:0]            ext_hburst;
    logic [2:0]            ext_hsize;
    logic [DATA_WIDTH-1:0] ext_hrdata;
    logic [1:0]            htrans;
    logic [1:0]            hresp;

    modport master (
        output start_trans, stop_trans, ext_haddr, ext_hwdata, ext_hwrite, ext_hburst, ext_hsize,
        input  ext_hrdata, htrans, hresp
    );

    modport slave (
        input  start_trans, stop_trans, ext_haddr, ext_hwdata, ext_hwrite, ext_hburst, ext_hsize,
        output ext_hrdata, htrans, hresp
    );
endinterface

// File: rtl/ahb_cmd_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after the pointer wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_winner
);
    localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0] w_pos;
    logic           w_found;

    always_comb begin
        o_winner = '0;
        w_pos    = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit so ptr+offset can exceed NUM_REQ-1 before the wrap subtract.
            w_pos = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_pos >= NREQ) w_pos = w_pos - NREQ;
            if (!w_found && i_req[w_pos[PTR_W-1:0]]) begin
                o_winner[w_pos[PTR_W-1:0]] = 1'b1;
                w_found                    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ahb_cmd_arbiter.sv
// Shares one AHB master command port among NUM_REQ requesters, round-robin,
// with a start-to-busy timeout and sticky error reporting.
module ahb_cmd_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*3-1:0]          req_burst,
    input  logic [NUM_REQ*3-1:0]          req_size,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic                          err,
    output logic [DATA_WIDTH-1:0]         rdata,
    ahb_cmd_arbiter_if.master             m_bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    arb_state_t            r_state, w_next;
    logic [PTR_W-1:0]      r_ptr, r_owner, w_win_idx;
    logic [NUM_REQ-1:0]    r_grant, w_win;
    logic [CNT_W-1:0]      r_cnt, w_cnt_inc;
    logic                  r_flag, w_timeout, w_bus_err;
    logic [DATA_WIDTH-1:0] r_rdata, r_hwdata, w_sel_wdata;
    logic [ADDR_WIDTH-1:0] r_haddr, w_sel_addr;
    logic                  r_hwrite, w_sel_write;
    logic [2:0]            r_hburst, r_hsize, w_sel_burst, w_sel_size;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_winner (w_win)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        w_sel_burst = '0;
        w_sel_size  = '0;
        w_win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) begin
                w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_write = req_write[i];
                w_sel_burst = req_burst[i*3 +: 3];
                w_sel_size  = req_size[i*3 +: 3];
                w_win_idx   = PTR_W'(i);
            end
        end
    end

    // Counter never exceeds TIMEOUT-1 while in WAIT_BUSY, so the increment cannot wrap.
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        w_bus_err = ((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_IDLE)) &&
                    (m_bus.hresp == HRESP_ERROR);
        case (r_state)
            ST_IDLE:      if (|req_valid) w_next = ST_START;
            ST_START:     w_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (m_bus.htrans != HTRANS_IDLE) begin
                    w_next = ST_WAIT_IDLE;
                end else if (w_cnt_inc >= CNT_MAX) begin
                    w_timeout = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_WAIT_IDLE: if (m_bus.htrans == HTRANS_IDLE) w_next = ST_DONE;
            ST_DONE:      w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_grant  <= '0;
            r_cnt    <= '0;
            r_flag   <= 1'b0;
            r_rdata  <= '0;
            r_haddr  <= '0;
            r_hwdata <= '0;
            r_hwrite <= 1'b0;
            r_hburst <= '0;
            r_hsize  <= '0;
        end else begin
            r_state <= w_next;
            if (w_bus_err || w_timeout) r_flag <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_haddr  <= w_sel_addr;
                        r_hwdata <= w_sel_wdata;
                        r_hwrite <= w_sel_write;
                        r_hburst <= w_sel_burst;
                        r_hsize  <= w_sel_size;
                        r_grant  <= w_win;
                        r_owner  <= w_win_idx;
                    end
                end
                ST_START:     r_cnt <= '0;
                ST_WAIT_BUSY: if (r_cnt != CNT_MAX) r_cnt <= w_cnt_inc;
                ST_WAIT_IDLE: if (m_bus.htrans == HTRANS_IDLE) r_rdata <= m_bus.ext_hrdata;
                ST_DONE: begin
                    r_grant <= '0;
                    r_flag  <= 1'b0;
                    r_ptr   <= (r_owner == PTR_LAST) ? '0 : r_owner + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign grant             = r_grant;
    assign done              = (r_state == ST_DONE) ? r_grant : '0;
    assign err               = (r_state == ST_DONE) && r_flag;
    assign rdata             = r_rdata;
    assign m_bus.start_trans = (r_state == ST_START);
    assign m_bus.stop_trans  = w_timeout;
    assign m_bus.ext_haddr   = r_haddr;
    assign m_bus.ext_hwdata  = r_hwdata;
    assign m_bus.ext_hwrite  = r_hwrite;
    assign m_bus.ext_hburst  = r_hburst;
    assign m_bus.ext_hsize   = r_hsize;
endmodule

// File: doc/ahb_cmd_arbiter.md
AHB_CMD_ARBITER -- requirements
Module: ahb_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one ahb_master command port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum cycles from start_trans until htrans leaves IDLE.
REQ-005 SHALL have ports: hclk  in  1  single clock, all logic on rising edge; one clock only.
REQ-006 SHALL have ports: hreset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: req_valid  in  NUM_REQ  per-requester request, held until its done.
REQ-008 SHALL have ports: req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i in slice i.
REQ-009 SHALL have ports: req_wdata  in  NUM_REQ*DATA_WIDTH; req_write  in  NUM_REQ; req_burst  in  NUM_REQ*3; req_size  in  NUM_REQ*3.
REQ-010 SHALL have ports: grant  out  NUM_REQ  one-hot owner; done  out  NUM_REQ  one-cycle completion pulse; err  out  1  valid with done; rdata  out  DATA_WIDTH  valid with done.
REQ-011 SHALL have master-side ports: start_trans, stop_trans  out  1; ext_haddr  out  ADDR_WIDTH; ext_hwdata  out  DATA_WIDTH; ext_hwrite  out  1; ext_hburst, ext_hsize  out  3; ext_hrdata  in  DATA_WIDTH; htrans  in  2; hresp  in  2.

Function
REQ-012 SHALL implement states IDLE, START, WAIT_BUSY, WAIT_IDLE, DONE.
REQ-013 IDLE: if any req_valid, SHALL select winner round-robin starting at pointer, latch its command into ext_* registers, set grant one-hot, go START; else stay, grant=0.
REQ-014 START: SHALL assert start_trans for exactly one cycle, clear timeout counter, go WAIT_BUSY.
REQ-015 WAIT_BUSY: htrans!=2'b00 SHALL go WAIT_IDLE; counter reaching TIMEOUT SHALL pulse stop_trans one cycle, set error flag, go DONE.
REQ-016 WAIT_IDLE: htrans==2'b00 SHALL capture ext_hrdata into rdata register, go DONE.
REQ-017 Any cycle in WAIT_BUSY/WAIT_IDLE with hresp==2'b01 (ERROR) SHALL set the sticky error flag.
REQ-018 DONE: SHALL pulse done[winner] one cycle with err=flag, rdata held; clear grant and flag; pointer=(winner+1) mod NUM_REQ; go IDLE.
REQ-019 Grant-to-start latency SHALL be 1 cycle; minimum request-to-done SHALL be 4 cycles plus master busy time.
REQ-020 ext_* outputs SHALL stay constant from IDLE latch until next latch; requester changes to its fields after grant are ignored.
REQ-021 Deassertion of req_valid by the owner mid-transaction SHALL NOT abort it; done still pulses.
REQ-022 Simultaneous requests SHALL be served in pointer order; a requester waits at most NUM_REQ-1 transactions.
REQ-023 Pointer wrap SHALL go NUM_REQ-1 -> 0; timeout counter width SHALL be $clog2(TIMEOUT+1), saturating.
REQ-024 done, start_trans, stop_trans SHALL never assert simultaneously; at most one done bit SHALL be high.

Reset
REQ-025 hreset high at a rising edge SHALL force state IDLE, pointer 0, grant 0, done 0, err 0, rdata 0, start_trans 0, stop_trans 0, all ext_* 0, error flag 0, counter 0.
REQ-026 Reset mid-transaction SHALL abandon it without done pulse; no stop_trans emitted.

Structure
REQ-027 Package ahb_arb_pkg SHALL hold state enum, HTRANS_IDLE=2'b00, HRESP_ERROR=2'b01 constants.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, pointer; output one-hot winner, combinational).

Verification
REQ-029 Single write: req_valid[0], addr 0x1000_0000, wdata 0xDEAD_BEEF, write=1 -> start_trans one pulse, ext_haddr=0x1000_0000, done[0] after htrans returns IDLE, err=0.
REQ-030 Read: req[2] read 0x1000_0000, ext_hrdata=0x0BAD_C0DE -> done[2] with rdata=0x0BAD_C0DE.
REQ-031 Contention: req_valid=4'b1111 from reset -> grant order 0,1,2,3, then 0 again if still requesting.
REQ-032 Timeout: htrans held 2'b00 after start -> stop_trans at cycle 16 after start, done with err=1.
REQ-033 Error: hresp=2'b01 one cycle during burst (hburst=3) -> done with err=1, next transaction err=0.
REQ-034 Reset in WAIT_IDLE -> all outputs 0 next cycle, no done, next grant goes to requester 0.
